// File: rtl/set_gen_pkg.sv
// rtl/set_gen_pkg.sv - shared types and width helpers for the set count generator
package set_gen_pkg;

    typedef enum logic [2:0] {
        MODE_A        = 3'b000,
        MODE_OR       = 3'b001,
        MODE_XOR      = 3'b010,
        MODE_AND      = 3'b011,
        MODE_ALL      = 3'b100,
        MODE_EXACT2   = 3'b101,
        MODE_ATLEAST2 = 3'b110,
        MODE_NONE     = 3'b111
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic int cand_w(input int grid);
        return $clog2(grid * grid + 1);
    endfunction

    function automatic int dist_sq_w(input int coord_w);
        return 2 * coord_w + 3;
    endfunction

endpackage

// File: rtl/set_member.sv
// rtl/set_member.sv - combinational test of one grid point against one circle
module set_member
    import set_gen_pkg::*;
#(
    parameter int COORD_W = 4
) (
    input  logic [COORD_W-1:0] px_i,
    input  logic [COORD_W-1:0] py_i,
    input  logic [COORD_W-1:0] cx_i,
    input  logic [COORD_W-1:0] cy_i,
    input  logic [COORD_W-1:0] r_i,
    output logic               hit_o
);

    localparam int SQ_W = dist_sq_w(COORD_W);
    localparam int EXT  = SQ_W - COORD_W - 1;

    logic signed [COORD_W:0] dx;
    logic signed [COORD_W:0] dy;
    logic signed [SQ_W-1:0]  dx_e;
    logic signed [SQ_W-1:0]  dy_e;
    logic        [SQ_W-1:0]  dx2;
    logic        [SQ_W-1:0]  dy2;
    logic        [SQ_W-1:0]  r_e;
    logic        [SQ_W-1:0]  r2;
    logic        [SQ_W-1:0]  d2;

    assign dx   = $signed({1'b0, px_i}) - $signed({1'b0, cx_i});
    assign dy   = $signed({1'b0, py_i}) - $signed({1'b0, cy_i});
    // Widen before squaring so neither the squares nor their sum can overflow
    assign dx_e = {{EXT{dx[COORD_W]}}, dx};
    assign dy_e = {{EXT{dy[COORD_W]}}, dy};
    assign dx2  = dx_e * dx_e;
    assign dy2  = dy_e * dy_e;
    assign r_e  = {{(SQ_W-COORD_W){1'b0}}, r_i};
    assign r2   = r_e * r_e;
    assign d2   = dx2 + dy2;
    assign hit_o = (d2 <= r2);

endmodule

// File: rtl/set_count_gen.sv
// rtl/set_count_gen.sv - counts grid points satisfying a set relation over up to four circles
module set_count_gen
    import set_gen_pkg::*;
#(
    parameter int COORD_W = 4,
    parameter int GRID    = 8,
    parameter int NCIRC   = 3,
    parameter int LANES   = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            en,
    input  logic [NCIRC*2*COORD_W-1:0]      central,
    input  logic [NCIRC*COORD_W-1:0]        radius,
    input  logic [2:0]                      mode,
    input  logic                            test_se,
    output logic                            busy,
    output logic                            valid,
    output logic [set_gen_pkg::cand_w(GRID)-1:0] candidate
);

    localparam int CAND_W = cand_w(GRID);
    localparam int NPTS   = GRID * GRID;
    localparam int SCAN_N = NPTS / LANES;
    localparam int CYC_W  = (SCAN_N > 1) ? $clog2(SCAN_N) : 1;
    localparam int LSUM_W = $clog2(LANES + 1);
    localparam int CEN_W  = NCIRC * 2 * COORD_W;
    localparam int RAD_W  = NCIRC * COORD_W;

    state_e              state_q, state_d;
    logic [CEN_W-1:0]    central_q, central_d;
    logic [RAD_W-1:0]    radius_q, radius_d;
    mode_e               mode_q, mode_d;
    logic                pend_q, pend_d;
    logic [COORD_W-1:0]  x_q, x_d;
    logic [COORD_W-1:0]  y_q, y_d;
    logic [CYC_W-1:0]    cyc_q, cyc_d;
    logic [CAND_W-1:0]   acc_q, acc_d;
    logic [CAND_W-1:0]   cand_q, cand_d;

    logic                accept;
    logic [COORD_W-1:0]  lane_x [LANES+1];
    logic [COORD_W-1:0]  lane_y [LANES+1];
    logic [LANES-1:0][NCIRC-1:0] hits;
    logic [2:0]          lane_cnt [LANES];
    logic [LANES-1:0]    lane_hit;
    logic [LSUM_W-1:0]   lane_sum;
    logic                unused_test_se;

    assign unused_test_se = test_se;

    // A pending start (en taken in DONE) keeps busy high through the IDLE hop
    assign busy      = (state_q == ST_SCAN) || ((state_q == ST_IDLE) && pend_q);
    assign valid     = (state_q == ST_DONE);
    assign candidate = cand_q;
    assign accept    = en && !busy;

    always_comb begin
        lane_x[0] = x_q;
        lane_y[0] = y_q;
        for (int l = 0; l < LANES; l++) begin
            if (lane_x[l] == COORD_W'(GRID)) begin
                lane_x[l+1] = COORD_W'(1);
                lane_y[l+1] = lane_y[l] + COORD_W'(1);
            end else begin
                lane_x[l+1] = lane_x[l] + COORD_W'(1);
                lane_y[l+1] = lane_y[l];
            end
        end
    end

    // Circle 0 (A) sits in the most significant slice of central/radius
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        for (genvar c = 0; c < NCIRC; c++) begin : g_circ
            set_member #(.COORD_W(COORD_W)) u_member (
                .px_i  (lane_x[l]),
                .py_i  (lane_y[l]),
                .cx_i  (central_q[(NCIRC-c)*2*COORD_W-1 -: COORD_W]),
                .cy_i  (central_q[(NCIRC-c)*2*COORD_W-COORD_W-1 -: COORD_W]),
                .r_i   (radius_q[(NCIRC-c)*COORD_W-1 -: COORD_W]),
                .hit_o (hits[l][c])
            );
        end
    end

    always_comb begin
        lane_hit = '0;
        lane_sum = '0;
        for (int l = 0; l < LANES; l++) begin
            lane_cnt[l] = 3'd0;
            for (int c = 0; c < NCIRC; c++) begin
                lane_cnt[l] = lane_cnt[l] + 3'(hits[l][c]);
            end
            case (mode_q)
                MODE_A:        lane_hit[l] = hits[l][0];
                MODE_OR:       lane_hit[l] = hits[l][0] | hits[l][1];
                MODE_XOR:      lane_hit[l] = hits[l][0] ^ hits[l][1];
                MODE_AND:      lane_hit[l] = hits[l][0] & hits[l][1];
                MODE_ALL:      lane_hit[l] = (lane_cnt[l] == 3'(NCIRC));
                MODE_EXACT2:   lane_hit[l] = (lane_cnt[l] == 3'd2);
                MODE_ATLEAST2: lane_hit[l] = (lane_cnt[l] >= 3'd2);
                MODE_NONE:     lane_hit[l] = (lane_cnt[l] == 3'd0);
                default:       lane_hit[l] = 1'b0;
            endcase
            lane_sum = lane_sum + LSUM_W'(lane_hit[l]);
        end
    end

    always_comb begin
        state_d   = state_q;
        central_d = central_q;
        radius_d  = radius_q;
        mode_d    = mode_q;
        pend_d    = pend_q;
        x_d       = x_q;
        y_d       = y_q;
        cyc_d     = cyc_q;
        acc_d     = acc_q;
        cand_d    = cand_q;
        if (accept) begin
            central_d = central;
            radius_d  = radius;
            mode_d    = mode_e'(mode);
        end
        case (state_q)
            ST_IDLE: begin
                if (pend_q || accept) begin
                    state_d = ST_SCAN;
                    pend_d  = 1'b0;
                    x_d     = COORD_W'(1);
                    y_d     = COORD_W'(1);
                    cyc_d   = '0;
                    acc_d   = '0;
                end
            end
            ST_SCAN: begin
                x_d   = lane_x[LANES];
                y_d   = lane_y[LANES];
                cyc_d = cyc_q + CYC_W'(1);
                acc_d = acc_q + CAND_W'(lane_sum);
                if (cyc_q == CYC_W'(SCAN_N - 1)) begin
                    state_d = ST_DONE;
                    cand_d  = acc_q + CAND_W'(lane_sum);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                pend_d  = accept;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            central_q <= '0;
            radius_q  <= '0;
            mode_q    <= MODE_A;
            pend_q    <= 1'b0;
            x_q       <= COORD_W'(1);
            y_q       <= COORD_W'(1);
            cyc_q     <= '0;
            acc_q     <= '0;
            cand_q    <= '0;
        end else begin
            state_q   <= state_d;
            central_q <= central_d;
            radius_q  <= radius_d;
            mode_q    <= mode_d;
            pend_q    <= pend_d;
            x_q       <= x_d;
            y_q       <= y_d;
            cyc_q     <= cyc_d;
            acc_q     <= acc_d;
            cand_q    <= cand_d;
        end
    end

endmodule
